// File: rtl/config_space_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : config_space_scanner
//  Description : Walks a list of PCIe cfg dword addresses over the core's CFG
//                read port and captures each dword into a packed register
//                bank. Supports per-entry timeout, forced or periodic rescan
//                and change detection against previously valid values.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_space_scanner #(
    parameter int                     NUM_REGS       = 8,
    parameter logic [10*NUM_REGS-1:0] ADDR_LIST      = {10'd11, 10'd10, 10'd9, 10'd8,
                                                        10'd7,  10'd6,  10'd5, 10'd4},
    parameter int                     TIMEOUT_CYCLES = 256,
    parameter int                     REFRESH_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_refresh,
    output logic                     o_busy,
    output logic                     o_finished,
    input  logic [31:0]              i_cfg_do,
    input  logic                     i_cfg_rd_wr_done,
    output logic [9:0]               o_cfg_dwaddr,
    output logic                     o_cfg_rd_en,
    output logic [32*NUM_REGS-1:0]   o_cfg_regs,
    output logic [NUM_REGS-1:0]      o_reg_valid,
    output logic [NUM_REGS-1:0]      o_changed_mask,
    output logic                     o_changed,
    output logic                     o_timeout
);

    localparam int c_IW = (NUM_REGS > 1)       ? $clog2(NUM_REGS)       : 1;
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NUM_REGS - 1);
    localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_RW-1:0] c_RF_LAST  = c_RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic            c_AUTO     = (REFRESH_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREP    = 3'd1,
        S_REQ     = 3'd2,
        S_CAPTURE = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_IW-1:0]   r_idx;
    logic [c_TW-1:0]   r_tcnt;
    logic [c_RW-1:0]   r_rcnt;

    logic              w_done_seen;
    logic              w_to_expire;
    logic              w_last;
    logic              w_rescan;
    logic [31:0]       w_cur_reg;
    logic [9:0]        w_addr_sel;

    assign w_done_seen = (r_state == S_REQ) && i_cfg_rd_wr_done;
    assign w_to_expire = (r_state == S_REQ) && !i_cfg_rd_wr_done && (r_tcnt == c_TO_LAST);
    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_rescan    = (r_state == S_DONE) && (i_refresh || (c_AUTO && (r_rcnt == c_RF_LAST)));
    assign w_cur_reg   = o_cfg_regs[32*int'(r_idx) +: 32];
    assign w_addr_sel  = ADDR_LIST[10*int'(r_idx) +: 10];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; dropping i_en aborts from any state
    always_comb begin
        w_next = r_state;
        if (!i_en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next = S_PREP;
                S_PREP:    w_next = S_REQ;
                S_REQ: begin
                    if (i_cfg_rd_wr_done) begin
                        w_next = S_CAPTURE;
                    end else if (w_to_expire) begin
                        w_next = S_RELEASE;
                    end
                end
                S_CAPTURE: w_next = S_RELEASE;
                // Next address must not change until the handshake has closed
                S_RELEASE: begin
                    if (!i_cfg_rd_wr_done) begin
                        w_next = w_last ? S_DONE : S_PREP;
                    end
                end
                S_DONE: begin
                    if (w_rescan) begin
                        w_next = S_PREP;
                    end
                end
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Registered outputs, index and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_busy         <= 1'b0;
            o_finished     <= 1'b0;
            o_cfg_dwaddr   <= ADDR_LIST[9:0];
            o_cfg_rd_en    <= 1'b0;
            o_cfg_regs     <= '0;
            o_reg_valid    <= '0;
            o_changed_mask <= '0;
            o_changed      <= 1'b0;
            o_timeout      <= 1'b0;
            r_idx          <= '0;
            r_tcnt         <= '0;
            r_rcnt         <= '0;
        end else begin
            o_changed <= 1'b0;

            // A completion seen in REQ is captured even if i_en falls this cycle
            if (w_done_seen) begin
                o_cfg_regs[32*int'(r_idx) +: 32] <= i_cfg_do;
                o_reg_valid[r_idx]               <= 1'b1;
                if (o_reg_valid[r_idx] && (w_cur_reg != i_cfg_do)) begin
                    o_changed_mask[r_idx] <= 1'b1;
                end
            end

            if (!i_en) begin
                o_cfg_rd_en <= 1'b0;
                o_busy      <= 1'b0;
                o_finished  <= 1'b0;
                r_idx       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_idx          <= '0;
                        o_finished     <= 1'b0;
                        o_busy         <= 1'b1;
                        o_changed_mask <= '0;
                    end
                    S_PREP: begin
                        o_cfg_dwaddr <= w_addr_sel;
                        r_tcnt       <= '0;
                        o_cfg_rd_en  <= 1'b1;
                    end
                    S_REQ: begin
                        if (i_cfg_rd_wr_done) begin
                            o_cfg_rd_en <= 1'b0;
                        end else if (w_to_expire) begin
                            o_cfg_rd_en        <= 1'b0;
                            o_reg_valid[r_idx] <= 1'b0;
                            o_timeout          <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + c_TW'(1);
                        end
                    end
                    S_CAPTURE: begin
                        o_cfg_rd_en <= 1'b0;
                    end
                    S_RELEASE: begin
                        if (!i_cfg_rd_wr_done) begin
                            if (w_last) begin
                                o_busy     <= 1'b0;
                                o_finished <= 1'b1;
                                o_changed  <= |o_changed_mask;
                                r_rcnt     <= '0;
                            end else begin
                                r_idx <= r_idx + c_IW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        if (w_rescan) begin
                            r_idx          <= '0;
                            o_finished     <= 1'b0;
                            o_busy         <= 1'b1;
                            o_changed_mask <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + c_RW'(1);
                        end
                    end
                    default: begin
                        o_cfg_rd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
